// File: rtl/seg7_hex_scan_pkg.sv
// Shared constants for the seven-segment hex scanner: segment table, idle
// patterns and digit-index width.
package seg7_pkg;

  localparam int IDX_W = 3;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {CG,CF,CE,CD,CC,CB,CA}, indexed by nibble value 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_scan_if.sv
// Bundle between the CPU-side word source and the display scanner,
// including the active-low board outputs.
interface seg7_hex_scan_if;

  logic        sel;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        hold;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output sel, pc, inst, hold, input an, seg, dp);
  modport slave  (input sel, pc, inst, hold, output an, seg, dp);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_hex_scan.sv
// Eight-digit multiplexed hex display scanner: prescaler, digit counter,
// tear-free frame latch, optional leading-zero blanking, registered outputs.
module seg7_hex_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic           clk_in,
  input  logic           reset,
  seg7_hex_scan_if.slave bus
);

  localparam int               CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_shown;
  logic             r_shownInst;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_tick;
  logic [IDX_W-1:0] w_nextIdx;
  logic             w_load;
  logic [31:0]      w_word;
  logic             w_wordInst;
  logic [3:0]       w_nibble;
  logic [31:0]      w_upper;
  logic             w_blank;
  logic [6:0]       w_decSeg;

  assign w_tick    = (r_cnt == CNT_MAX);
  assign w_nextIdx = r_idx + IDX_W'(1);
  assign w_load    = w_tick && (w_nextIdx == '0) && !bus.hold;

  // Bypass so digit 0 shows the word being latched on the same edge
  assign w_word     = w_load ? (bus.sel ? bus.inst : bus.pc) : r_shown;
  assign w_wordInst = w_load ? bus.sel : r_shownInst;

  assign w_nibble = w_word[{w_nextIdx, 2'b00} +: 4];
  assign w_upper  = w_word >> {w_nextIdx, 2'b00};
  assign w_blank  = BLANK_LZ && (w_nextIdx != '0) && (w_upper == 32'd0);

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_decSeg)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= IDX_W'(7);
      r_shown     <= '0;
      r_shownInst <= 1'b0;
      r_an        <= AN_OFF;
      r_seg       <= SEG_OFF;
      r_dp        <= 1'b1;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) begin
        r_idx <= w_nextIdx;
        if (w_load) begin
          r_shown     <= w_word;
          r_shownInst <= bus.sel;
        end
        r_an  <= ~(8'd1 << w_nextIdx);
        r_seg <= w_blank ? SEG_OFF : w_decSeg;
        r_dp  <= !((w_nextIdx == IDX_W'(7)) && w_wordInst);
      end
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
